uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_puf_pkg.sv | 18 +
 rtl/rr_priority_picker.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_puf_pkg.sv
// rtl/uart_puf_pkg.sv - shared types and constants for the UART packet arbiter
package uart_puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;
    localparam int         WD_WIDTH   = 16;

    // Header byte announcing which requester owns the following packet
    function automatic logic [7:0] hdr_byte(input logic [3:0] id);
        return {HDR_NIBBLE, id};
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - wrap-around first-set search starting at a pointer
module rr_priority_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_o
);

    logic [IDX_W:0] idx;

    // Walk indices start, start+1, ... modulo NUM_REQ; first requester seen wins
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, start_i} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_REQ)) begin
                idx = idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!any_o && req_i[idx[IDX_W-1:0]]) begin
                winner_o = idx[IDX_W-1:0];
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter feeding one UART byte stream
module uart_tx_arbiter
    import uart_puf_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT_CYC = 1000,
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                 clk_100mhz,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [IDX_W-1:0]     err_id
);

    state_e                state_q, state_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WD_WIDTH-1:0]   wd_q, wd_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [IDX_W-1:0]      err_id_q, err_id_d;

    logic                  out_free;
    logic                  load;
    logic [7:0]            load_byte;
    logic                  g_valid;
    logic                  g_last;
    logic [7:0]            g_data;
    logic [IDX_W-1:0]      next_ptr;
    logic [WD_WIDTH-1:0]   wd_inc;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i    (req_valid),
        .start_i  (rr_ptr_q),
        .winner_o (pick_idx),
        .any_o    (pick_any)
    );

    assign out_free = !tx_valid_q || tx_ready;
    assign g_valid  = req_valid[grant_q];
    assign g_last   = req_last[grant_q];
    assign g_data   = req_data[{grant_q, 3'b000} +: 8];
    assign next_ptr = (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
    assign wd_inc   = wd_q + 1'b1;

    // Packet sequencing, watchdog and the load request into the output register
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        wd_d          = wd_q;
        timeout_err_d = 1'b0;
        err_id_d      = err_id_q;
        req_ready     = '0;
        load          = 1'b0;
        load_byte     = 8'h00;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_byte = hdr_byte(4'(grant_q));
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                req_ready[grant_q] = out_free;
                if (g_valid && out_free) begin
                    load      = 1'b1;
                    load_byte = g_data;
                    wd_d      = '0;
                    if (g_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (!g_valid) begin
                    // Stall counting only while the owner has nothing to offer
                    if (wd_inc == WD_WIDTH'(TIMEOUT_CYC)) begin
                        state_d       = ST_IDLE;
                        timeout_err_d = 1'b1;
                        err_id_d      = grant_q;
                        rr_ptr_d      = next_ptr;
                        wd_d          = '0;
                    end else begin
                        wd_d = wd_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: a load wins over a drain so back-to-back bytes keep tx_valid high
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (load) begin
            tx_valid_d = 1'b1;
            tx_data_d  = load_byte;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset dropping any in-flight byte
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
            err_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
            err_id_q      <= err_id_d;
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;
    assign err_id      = err_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized bench with packet-level round-robin reference model
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;

    logic           clk_100mhz = 1'b0;
    logic           reset      = 1'b1;
    logic [N-1:0]   req_valid  = '0;
    logic [8*N-1:0] req_data   = '0;
    logic [N-1:0]   req_last   = '0;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready   = 1'b0;
    logic [1:0]     grant_id;
    logic           busy;
    logic           timeout_err;
    logic [1:0]     err_id;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk_100mhz  (clk_100mhz),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_id      (err_id)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mem_d [N][256];
    bit         mem_l [N][256];
    int         wr_p [N];
    int         rd_p [N];
    int         gap  [N];
    bit         stall_en [N];
    bit         stalled  [N];
    int         gap_max  = 0;
    int         tx_mode  = 1;
    bit         tx_force = 1'b1;

    logic [7:0] exp_q [$];
    int         cyc = 0;
    int         ph_xf = 0;
    int         first_xf_cyc = 0;
    int         last_xf_cyc = 0;
    int         n_to = 0;
    bit         hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    bit         last_xf_busy = 1'b0;
    bit         prev_xf_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input bit l);
        mem_d[r][wr_p[r]] = d;
        mem_l[r][wr_p[r]] = l;
        wr_p[r] = wr_p[r] + 1;
    endtask

    task automatic add_pkt(input int r, input int len);
        for (int i = 0; i < len; i++) add_byte(r, 8'($urandom), i == len - 1);
    endtask

    // Reference: whole packets granted round-robin among requesters with packets pending
    task automatic model_rr(input int start);
        int p [N];
        int ptr;
        int w;
        int r;
        bit done;
        ptr = start;
        for (int i = 0; i < N; i++) p[i] = rd_p[i];
        while (1) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                r = (ptr + k) % N;
                if (w < 0 && p[r] < wr_p[r]) w = r;
            end
            if (w < 0) break;
            exp_q.push_back(8'hA0 | 8'(w));
            done = 1'b0;
            while (!done) begin
                exp_q.push_back(mem_d[w][p[w]]);
                done = mem_l[w][p[w]];
                p[w] = p[w] + 1;
            end
            ptr = (w + 1) % N;
        end
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            req_valid[r]       = (rd_p[r] < wr_p[r]) && (gap[r] == 0) && !stalled[r];
            req_data[8*r +: 8] = mem_d[r][rd_p[r]];
            req_last[r]        = mem_l[r][rd_p[r]];
        end
        tx_ready = (tx_mode == 0) ? ($urandom_range(0, 3) != 0) : tx_force;
    endtask

    task automatic step();
        logic [N-1:0] acc;
        logic [7:0]   e;
        acc = '0;
        @(negedge clk_100mhz);
        if (!reset) begin
            acc = req_valid & req_ready;
            if (hold_prev) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, hold_data);
            end
            if (tx_valid && !tx_ready) check("ready_backpressure", req_ready, 0);
            check("ready_owner_only", ($countones(req_ready) <= 1) && (busy || req_ready == 0), 1);
            if (timeout_err) begin
                n_to = n_to + 1;
                for (int r = 0; r < N; r++) begin
                    if (stall_en[r]) begin
                        rd_p[r] = wr_p[r];
                        stall_en[r] = 1'b0;
                        stalled[r] = 1'b0;
                    end
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("tx_extra_byte", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_data, e);
                end
                if (ph_xf == 0) first_xf_cyc = cyc;
                last_xf_cyc  = cyc;
                ph_xf        = ph_xf + 1;
                prev_xf_busy = last_xf_busy;
                last_xf_busy = busy;
            end
            hold_prev = tx_valid && !tx_ready;
            hold_data = tx_data;
        end else begin
            hold_prev = 1'b0;
        end
        @(posedge clk_100mhz);
        cyc = cyc + 1;
        #1;
        for (int r = 0; r < N; r++) begin
            if (acc[r]) begin
                rd_p[r] = rd_p[r] + 1;
                gap[r]  = (mem_l[r][rd_p[r]-1] || gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
                if (stall_en[r]) stalled[r] = 1'b1;
            end else if (gap[r] > 0) begin
                gap[r] = gap[r] - 1;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_err_id", err_id, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_req_ready", req_ready, 0);
        reset = 1'b0;
        ph_xf = 0;
        for (int r = 0; r < N; r++) gap[r] = 0;
    endtask

    task automatic run_done(input int max);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy || tx_valid) && i < max) begin
            step();
            i++;
        end
        check("drain_expected", exp_q.size(), 0);
        check("drain_idle", busy, 0);
    endtask

    task automatic wait_xf(input int n);
        int i;
        i = 0;
        while (ph_xf < n && i < 100) begin
            step();
            i++;
        end
        check("wait_transfers", ph_xf >= n, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < N; r++) begin
            wr_p[r] = 0; rd_p[r] = 0; gap[r] = 0; stall_en[r] = 1'b0; stalled[r] = 1'b0;
        end

        // Single packet from requester 2
        do_reset();
        tx_mode = 1; tx_force = 1'b1;
        add_byte(2, 8'h11, 1'b0);
        add_byte(2, 8'h22, 1'b1);
        model_rr(0);
        drive();
        run_done(50);
        check("single_count", ph_xf, 3);
        check("single_busy_at_last", last_xf_busy, 0);
        check("single_busy_before_last", prev_xf_busy, 1);

        // Contention between requesters 0, 1 and 3
        do_reset();
        tx_mode = 0;
        add_pkt(0, 1); add_pkt(1, 1); add_pkt(3, 1);
        model_rr(0);
        drive();
        run_done(200);
        check("contention_count", ph_xf, 6);

        // Backpressure: tx_ready held low five cycles mid-packet
        do_reset();
        tx_mode = 1; tx_force = 1'b1;
        add_pkt(1, 8);
        model_rr(0);
        drive();
        wait_xf(4);
        tx_force = 1'b0; tx_ready = 1'b0;
        repeat (5) step();
        tx_force = 1'b1; tx_ready = 1'b1;
        run_done(100);
        check("backpressure_count", ph_xf, 9);

        // Randomized traffic with short mid-packet gaps
        for (int round = 0; round < 3; round++) begin
            do_reset();
            tx_mode = 0; gap_max = 2;
            for (int r = 0; r < N; r++) begin
                repeat ($urandom_range(0, 3)) add_pkt(r, int'($urandom_range(1, 6)));
            end
            model_rr(0);
            drive();
            run_done(2000);
            check("random_no_timeout", n_to, 0);
        end
        gap_max = 0;

        // Timeout: requester 1 stalls after its first byte, requester 2 waits
        do_reset();
        tx_mode = 1; tx_force = 1'b1;
        add_pkt(1, 3);
        add_pkt(2, 2);
        exp_q.push_back(8'hA1);
        exp_q.push_back(mem_d[1][rd_p[1]]);
        exp_q.push_back(8'hA2);
        exp_q.push_back(mem_d[2][rd_p[2]]);
        exp_q.push_back(mem_d[2][rd_p[2]+1]);
        stall_en[1] = 1'b1;
        drive();
        run_done(200);
        check("timeout_pulses", n_to, 1);
        check("timeout_err_id", err_id, 1);

        // Reset mid-packet, then priority restarts at requester 0
        ph_xf = 0;
        add_pkt(1, 1);
        add_pkt(2, 6);
        model_rr(3);
        drive();
        wait_xf(4);
        check("midreset_in_packet", busy, 1);
        for (int r = 0; r < N; r++) rd_p[r] = wr_p[r];
        exp_q.delete();
        do_reset();
        check("midreset_no_timeout", n_to, 1);
        add_pkt(3, 1);
        add_pkt(0, 1);
        model_rr(0);
        drive();
        run_done(100);
        check("midreset_count", ph_xf, 4);

        // Throughput: 16-byte packet streams without bubbles
        do_reset();
        tx_mode = 1; tx_force = 1'b1;
        add_pkt(3, 16);
        model_rr(0);
        drive();
        run_done(100);
        check("throughput_count", ph_xf, 17);
        check("throughput_span", last_xf_cyc - first_xf_cyc, 16);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
